alu_issue_ctrl: RTL and testbench

//   Issue side of the ALU control interface. Accepts one RV32I R/I-type ALU

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_instr_encoder.sv | 55 +++++
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, RV32I opcode
// and funct7 values, and the issue FSM state encoding.
package alu_pkg;

    // 8-bit operation codes understood by alu_control
    localparam logic [7:0] ALU_IDLE = 8'h00;
    localparam logic [7:0] ALU_ADD  = 8'h06;
    localparam logic [7:0] ALU_SUB  = 8'h07;
    localparam logic [7:0] ALU_AND  = 8'h08;
    localparam logic [7:0] ALU_OR   = 8'h09;
    localparam logic [7:0] ALU_XOR  = 8'h0A;
    localparam logic [7:0] ALU_SLL  = 8'h0B;
    localparam logic [7:0] ALU_SRL  = 8'h0C;
    localparam logic [7:0] ALU_SLT  = 8'h0D;
    localparam logic [7:0] ALU_SRA  = 8'h0F;

    // RV32I major opcodes handled by this block
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;

    // funct7 (or imm[11:5] for immediate shifts)
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Issue FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/alu_instr_encoder.sv
// Combinational RV32I R/I-type instruction word to 8-bit ALU code.
// An instruction is illegal exactly when no code can be produced.
module alu_instr_encoder
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [7:0]  code_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_r;
    logic       is_i;
    logic       base_ok;
    logic       unused_fields;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign is_r   = (opcode == OPC_RTYPE);
    assign is_i   = (opcode == OPC_ITYPE);
    // Non-shift ops: I-type has a free immediate, R-type needs funct7 zero
    assign base_ok = is_i || (funct7 == F7_BASE);

    // Register indices are not needed to pick the operation
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    // Decode funct3/funct7 into an op code; ALU_IDLE marks "not encodable"
    always_comb begin
        code_o = ALU_IDLE;
        if (is_r || is_i) begin
            case (funct3)
                3'b000: begin
                    if (is_r && funct7 == F7_ALT) code_o = ALU_SUB;
                    else if (base_ok)             code_o = ALU_ADD;
                end
                3'b111:  if (base_ok) code_o = ALU_AND;
                3'b110:  if (base_ok) code_o = ALU_OR;
                3'b100:  if (base_ok) code_o = ALU_XOR;
                3'b010:  if (base_ok) code_o = ALU_SLT;
                3'b001:  if (funct7 == F7_BASE) code_o = ALU_SLL;
                3'b101: begin
                    if (funct7 == F7_BASE)     code_o = ALU_SRL;
                    else if (funct7 == F7_ALT) code_o = ALU_SRA;
                end
                default: code_o = ALU_IDLE;
            endcase
        end
    end

    assign illegal_o = (code_o == ALU_IDLE);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue side of the ALU control interface: accepts one instruction per
// handshake, pulses alu_en with the encoded op for one cycle, waits ALU_LAT
// cycles, captures alu_result and holds it with rd until writeback takes it.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALU_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic [7:0]        alu_instruction,
    output logic              alu_en,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_rd,
    output logic              out_illegal
);

    // Counter preload on entering WAIT; unused when the ALU is combinational
    localparam logic [3:0] LAT_M1 = (ALU_LAT > 0) ? 4'(ALU_LAT - 1) : 4'd0;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              alu_en_q, alu_en_d;
    logic [7:0]        alu_instr_q, alu_instr_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_illegal_q, out_illegal_d;

    logic [7:0]        enc_code;
    logic              enc_illegal;
    logic              accept;

    alu_instr_encoder u_encoder (
        .instr_i   (in_instr),
        .code_o    (enc_code),
        .illegal_o (enc_illegal)
    );

    // Drain and refill may happen in the same cycle, hence out_ready here
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Next-state and output-register logic; a handshake overrides the
    // IDLE/DONE transition so back-to-back ops have no bubble
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_en_d      = 1'b0;
        alu_instr_d   = ALU_IDLE;
        out_result_d  = out_result_q;
        out_rd_d      = out_rd_q;
        out_illegal_d = out_illegal_q;

        case (state_q)
            ST_ISSUE: begin
                if (ALU_LAT == 0) begin
                    out_result_d = alu_result;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    out_result_d = alu_result;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            out_rd_d      = in_instr[11:7];
            out_illegal_d = enc_illegal;
            if (enc_illegal) begin
                out_result_d = '0;
                state_d      = ST_DONE;
            end else begin
                alu_en_d    = 1'b1;
                alu_instr_d = enc_code;
                state_d     = ST_ISSUE;
            end
        end
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            alu_en_q      <= 1'b0;
            alu_instr_q   <= ALU_IDLE;
            out_result_q  <= '0;
            out_rd_q      <= 5'd0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_en_q      <= alu_en_d;
            alu_instr_q   <= alu_instr_d;
            out_result_q  <= out_result_d;
            out_rd_q      <= out_rd_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign alu_en          = alu_en_q;
    assign alu_instruction = alu_instr_q;
    assign out_valid       = (state_q == ST_DONE);
    assign out_result      = out_result_q;
    assign out_rd          = out_rd_q;
    assign out_illegal     = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: one instance with a combinational ALU model and
// one with ALU_LAT=3 fed by a cycle counter, checked through a scoreboard.
module tb_alu_issue_ctrl;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  code;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [7:0]  code;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        ill;
        int          en_cyc;
        int          done_cyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        vld[2];
    logic        rdy[2];
    logic [31:0] ins[2];
    logic [7:0]  ains[2];
    logic        aen[2];
    logic [31:0] ares[2];
    logic        ovld[2];
    logic        ordy[2];
    logic [31:0] ores[2];
    logic [4:0]  ord[2];
    logic        oill[2];

    txn_t        exp_q[2][$];
    txn_t        en_q[2][$];
    bit          seen[2];
    vec_t        tab[17];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int d);
        return d * 3;
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            alu_issue_ctrl #(.DATA_W(32), .ALU_LAT(gi * 3)) u_dut (
                .clk             (clk),
                .rst_n           (rst_n),
                .in_valid        (vld[gi]),
                .in_ready        (rdy[gi]),
                .in_instr        (ins[gi]),
                .alu_instruction (ains[gi]),
                .alu_en          (aen[gi]),
                .alu_result      (ares[gi]),
                .out_valid       (ovld[gi]),
                .out_ready       (ordy[gi]),
                .out_result      (ores[gi]),
                .out_rd          (ord[gi]),
                .out_illegal     (oill[gi])
            );

            if (gi == 0) begin : g_comb_alu
                // Valid only while enabled, so a mistimed sample shows DEADBEEF
                assign ares[gi] = aen[gi] ? {24'h5A5A00, ains[gi]} : 32'hDEADBEEF;
            end else begin : g_slow_alu
                assign ares[gi] = 32'(cyc);
            end

            // Monitor: alu_en pulses and out_* against the scoreboard
            always @(negedge clk) begin
                txn_t t;
                #1;
                if (rst_n) begin
                    if (en_q[gi].size() == 0) begin
                        check($sformatf("d%0d_en_spurious", gi), 32'(aen[gi]), 32'd0);
                    end else if (aen[gi]) begin
                        t = en_q[gi].pop_front();
                        check($sformatf("d%0d_en_code", gi), 32'(ains[gi]), 32'(t.code));
                        check($sformatf("d%0d_en_cycle", gi), 32'(cyc), 32'(t.en_cyc));
                    end else if (cyc >= en_q[gi][0].en_cyc) begin
                        check($sformatf("d%0d_en_missing", gi), 32'(aen[gi]), 32'd1);
                        void'(en_q[gi].pop_front());
                    end
                    if (!aen[gi])
                        check($sformatf("d%0d_instr_idle", gi), 32'(ains[gi]), 32'd0);

                    if (exp_q[gi].size() == 0) begin
                        check($sformatf("d%0d_valid_spurious", gi), 32'(ovld[gi]), 32'd0);
                    end else if (ovld[gi]) begin
                        t = exp_q[gi][0];
                        if (!seen[gi])
                            check($sformatf("d%0d_out_cycle", gi), 32'(cyc), 32'(t.done_cyc));
                        seen[gi] = 1'b1;
                        check($sformatf("d%0d_out_result", gi), ores[gi], t.res);
                        check($sformatf("d%0d_out_rd", gi), 32'(ord[gi]), 32'(t.rd));
                        check($sformatf("d%0d_out_illegal", gi), 32'(oill[gi]), 32'(t.ill));
                        if (ordy[gi]) begin
                            void'(exp_q[gi].pop_front());
                            seen[gi] = 1'b0;
                        end
                    end else if (cyc >= exp_q[gi][0].done_cyc) begin
                        check($sformatf("d%0d_valid_missing", gi), 32'(ovld[gi]), 32'd1);
                        void'(exp_q[gi].pop_front());
                        seen[gi] = 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Drive one table entry; on acceptance push the expected pulse/result
    task automatic send(input int d, input int idx, input bit drain_same);
        txn_t t;
        bit   ok;
        int   waited;
        ok = 1'b0;
        waited = 0;
        @(negedge clk);
        if (drain_same) ordy[d] = 1'b1;
        vld[d] = 1'b1;
        ins[d] = tab[idx].instr;
        for (int n = 0; n < 64 && !ok; n++) begin
            #1;
            if (rdy[d]) ok = 1'b1;
            else begin
                waited++;
                @(negedge clk);
            end
        end
        if (!ok) begin
            check($sformatf("d%0d_accept_timeout", d), 32'd0, 32'd1);
            vld[d] = 1'b0;
            return;
        end
        if (drain_same) check($sformatf("d%0d_same_cycle_accept", d), 32'(waited), 32'd0);
        t.code     = tab[idx].code;
        t.rd       = tab[idx].instr[11:7];
        t.ill      = tab[idx].ill;
        t.en_cyc   = cyc + 1;
        t.done_cyc = t.ill ? cyc + 1 : cyc + 2 + lat_of(d);
        if (t.ill)       t.res = 32'd0;
        else if (d == 0) t.res = {24'h5A5A00, t.code};
        else             t.res = 32'(cyc + 1 + lat_of(d));
        exp_q[d].push_back(t);
        if (!t.ill) en_q[d].push_back(t);
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
        ins[d] = $urandom;
    endtask

    task automatic check_reset_outputs(input int d, input string when);
        check($sformatf("d%0d_%s_alu_en", d, when), 32'(aen[d]), 32'd0);
        check($sformatf("d%0d_%s_alu_instr", d, when), 32'(ains[d]), 32'd0);
        check($sformatf("d%0d_%s_out_valid", d, when), 32'(ovld[d]), 32'd0);
        check($sformatf("d%0d_%s_out_result", d, when), ores[d], 32'd0);
        check($sformatf("d%0d_%s_out_rd", d, when), 32'(ord[d]), 32'd0);
        check($sformatf("d%0d_%s_out_illegal", d, when), 32'(oill[d]), 32'd0);
    endtask

    task automatic wait_drain(input int d);
        for (int n = 0; n < 200 && exp_q[d].size() != 0; n++) @(negedge clk);
        check($sformatf("d%0d_drain", d), 32'(exp_q[d].size()), 32'd0);
    endtask

    initial begin
        tab[0]  = '{32'h002081B3, 8'h06, 1'b0}; // add  x3,x1,x2
        tab[1]  = '{32'h402081B3, 8'h07, 1'b0}; // sub  x3,x1,x2
        tab[2]  = '{32'h40335293, 8'h0F, 1'b0}; // srai x5,x6,3
        tab[3]  = '{32'h0020B1B3, 8'h00, 1'b1}; // sltu x3 (unsupported)
        tab[4]  = '{32'h00500093, 8'h06, 1'b0}; // addi x1,x0,5
        tab[5]  = '{32'h00F0F113, 8'h08, 1'b0}; // andi x2,x1,15
        tab[6]  = '{32'h00316233, 8'h09, 1'b0}; // or   x4,x2,x3
        tab[7]  = '{32'h0020C333, 8'h0A, 1'b0}; // xor  x6,x1,x2
        tab[8]  = '{32'h002093B3, 8'h0B, 1'b0}; // sll  x7,x1,x2
        tab[9]  = '{32'h0020D433, 8'h0C, 1'b0}; // srl  x8,x1,x2
        tab[10] = '{32'h0020A4B3, 8'h0D, 1'b0}; // slt  x9,x1,x2
        tab[11] = '{32'hFFF0A513, 8'h0D, 1'b0}; // slti x10,x1,-1
        tab[12] = '{32'h40008093, 8'h06, 1'b0}; // addi x1,x1,1024 (never SUB)
        tab[13] = '{32'h0000A083, 8'h00, 1'b1}; // lw   (wrong opcode)
        tab[14] = '{32'h40109093, 8'h00, 1'b1}; // slli with funct7 0100000
        tab[15] = '{32'h022081B3, 8'h00, 1'b1}; // mul  (funct7 0000001)
        tab[16] = '{32'h4020F1B3, 8'h00, 1'b1}; // and with funct7 0100000

        for (int d = 0; d < 2; d++) begin
            vld[d]  = 1'b0;
            ins[d]  = 32'h0;
            ordy[d] = 1'b1;
            seen[d] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) check_reset_outputs(d, "reset");
        @(negedge clk);
        #3 rst_n = 1'b1;

        // Full table on both latencies, back-to-back where the DUT allows
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 17; i++) send(d, i, 1'b0);
            wait_drain(d);
        end

        // Writeback stall in DONE, then drain and accept in the same cycle
        @(negedge clk);
        ordy[0] = 1'b0;
        send(0, 0, 1'b0);
        for (int n = 0; n < 20 && !ovld[0]; n++) begin
            @(negedge clk);
            #1;
        end
        for (int n = 0; n < 5; n++) begin
            check("d0_hold_in_ready", 32'(rdy[0]), 32'd0);
            check("d0_hold_valid", 32'(ovld[0]), 32'd1);
            @(negedge clk);
            #1;
        end
        send(0, 6, 1'b1);
        send(0, 3, 1'b0);
        wait_drain(0);

        // Reset while the slow instance sits in WAIT
        send(1, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs(1, "midreset");
        check_reset_outputs(0, "midreset");
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            en_q[d].delete();
            seen[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("d1_after_reset_valid", 32'(ovld[1]), 32'd0);

        // Recovery after reset
        send(1, 2, 1'b0);
        send(1, 3, 1'b0);
        wait_drain(1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
